sdram_sim_mc: RTL

Parametrised N-channel, byte-wide behavioural SDRAM controller model for Verilator builds. Replaces the fixed 3-channel sim controller in the same system position. Adds round-robin arbitration, real byte-lane writes, coherent per-channel read-word caches, an internal refresh timer and a req/ack handshake. The word store is an internal 16-bit array. No pin-level SDRAM bus.

---
 rtl/sdram_sim_mc_pkg.sv | 24 ++
 rtl/sdram_sim_mc_if.sv | 15 +
 rtl/sdram_sim_mc_rr_arbiter.sv | 42 ++++
 rtl/sdram_sim_mc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_sim_mc_pkg.sv
// Shared state encoding and helpers for the behavioural N-channel SDRAM controller model.
package sdram_sim_mc_pkg;

    typedef enum logic [2:0] {INIT, IDLE, ACCESS, DONE, REFRESH} state_e;

    // Bits needed to hold the values 0 .. n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [7:0] lane_get(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

    function automatic logic [15:0] lane_put(input logic [15:0] word, input logic hi,
                                             input logic [7:0] b);
        logic [15:0] r;
        r = word;
        if (hi) r[15:8] = b;
        else    r[7:0]  = b;
        return r;
    endfunction

endpackage

// File: rtl/sdram_sim_mc_if.sv
// Client-side request/acknowledge bundle for all channels of the SDRAM controller model.
interface sdram_sim_mc_if #(
    parameter int NCH    = 4,
    parameter int ADDR_W = 25
);
    logic [NCH-1:0]        ch_req;
    logic [NCH-1:0]        ch_we;
    logic [NCH*ADDR_W-1:0] ch_addr;
    logic [NCH*8-1:0]      ch_din;
    logic [NCH*8-1:0]      ch_dout;
    logic [NCH-1:0]        ch_ack;

    modport master (output ch_req, ch_we, ch_addr, ch_din, input ch_dout, ch_ack);
    modport slave  (input ch_req, ch_we, ch_addr, ch_din, output ch_dout, ch_ack);
endinterface

// File: rtl/sdram_sim_mc_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping cyclically.
module rr_arbiter
    import sdram_sim_mc_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]                req_i,
    input  logic [cnt_width(NCH)-1:0]     ptr_i,
    output logic [NCH-1:0]                grant_o,
    output logic [cnt_width(NCH)-1:0]     idx_o,
    output logic                          valid_o
);
    localparam int IDX_W = cnt_width(NCH);
    localparam int SW    = IDX_W + 1;

    logic [2*NCH-1:0] req2;
    logic [2*NCH-1:0] rot2;
    logic [NCH-1:0]   rot;
    logic [SW-1:0]    sum;
    logic             found;

    // Rotate so the pointer channel sits at bit 0, then take the lowest set bit.
    always_comb begin
        req2  = {req_i, req_i};
        rot2  = req2 >> ptr_i;
        rot   = rot2[NCH-1:0];
        found = 1'b0;
        sum   = '0;
        for (int j = 0; j < NCH; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_i} + SW'(j);
            end
        end
        if (sum >= SW'(NCH)) sum = sum - SW'(NCH);
        idx_o   = sum[IDX_W-1:0];
        valid_o = found;
        grant_o = '0;
        if (found) grant_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/sdram_sim_mc.sv
// Behavioural N-channel byte-wide SDRAM controller: round-robin arbitration, per-channel
// read-word caches kept coherent on writes, internal refresh timer, req/ack handshake.
module sdram_sim_mc
    import sdram_sim_mc_pkg::*;
#(
    parameter int NCH              = 4,
    parameter int ADDR_W           = 25,
    parameter int ACCESS_CYCLES    = 5,
    parameter int REFRESH_INTERVAL = 780,
    parameter int REFRESH_CYCLES   = 6,
    parameter int INIT_CYCLES      = 32
) (
    input  logic          clk,
    input  logic          reset,
    sdram_sim_mc_if.slave bus,
    input  logic          refresh,
    output logic          ready,
    output logic          refresh_active
);
    localparam int WA_W    = ADDR_W - 1;
    localparam int IDX_W   = cnt_width(NCH);
    localparam int SEQ_A   = (INIT_CYCLES > ACCESS_CYCLES) ? INIT_CYCLES : ACCESS_CYCLES;
    localparam int SEQ_MAX = (SEQ_A > REFRESH_CYCLES) ? SEQ_A : REFRESH_CYCLES;
    localparam int CNT_W   = cnt_width(SEQ_MAX);
    localparam int RC_W    = cnt_width(REFRESH_INTERVAL);
    localparam int DEPTH   = 2 ** WA_W;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic             pend_q, pend_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [IDX_W-1:0] gidx_q;
    logic [WA_W-1:0]  waddr_q;
    logic             lane_q;
    logic             we_q;
    logic [7:0]       din_q;

    logic [NCH-1:0]   cvld_q;
    logic [WA_W-1:0]  ctag_q [NCH];
    logic [15:0]      cdat_q [NCH];
    logic [NCH*8-1:0] dout_q;
    logic [15:0]      mem    [DEPTH];

    logic [NCH-1:0]    arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [7:0]        sel_din;
    logic              sel_hit;
    logic              take_ref, take_req, acc_last, rtick;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req_i   (bus.ch_req),
        .ptr_i   (ptr_q),
        .grant_o (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_vld)
    );

    always_comb begin
        sel_addr = '0;
        sel_we   = 1'b0;
        sel_din  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (arb_gnt[i]) begin
                sel_addr = bus.ch_addr[i*ADDR_W +: ADDR_W];
                sel_we   = bus.ch_we[i];
                sel_din  = bus.ch_din[i*8 +: 8];
            end
        end
        sel_hit  = cvld_q[arb_idx] && (ctag_q[arb_idx] == sel_addr[ADDR_W-1:1]);
        take_ref = (state_q == IDLE) && pend_q;
        take_req = (state_q == IDLE) && !pend_q && arb_vld;
        acc_last = (state_q == ACCESS) && (cnt_q == CNT_W'(ACCESS_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            pend_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        rtick   = 1'b0;
        rcnt_d  = rcnt_q;
        if (state_q != INIT) begin
            if (rcnt_q == RC_W'(REFRESH_INTERVAL - 1)) begin
                rcnt_d = '0;
                rtick  = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
        // Pending is a single flag: a new event while one is outstanding merges into it.
        pend_d = (pend_q && !take_ref) || rtick || refresh;

        case (state_q)
            INIT: begin
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (take_ref) begin
                    state_d = REFRESH;
                end else if (take_req) begin
                    state_d = (!sel_we && sel_hit) ? DONE : ACCESS;
                    ptr_d   = (arb_idx == IDX_W'(NCH - 1)) ? '0 : arb_idx + 1'b1;
                end
            end
            ACCESS: begin
                if (acc_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            REFRESH: begin
                if (cnt_q == CNT_W'(REFRESH_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        bus.ch_ack = '0;
        if (state_q == DONE) bus.ch_ack[gidx_q] = 1'b1;
        ready          = (state_q != INIT);
        refresh_active = (state_q == REFRESH);
    end

    assign bus.ch_dout = dout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cvld_q <= '0;
            dout_q <= '0;
        end else begin
            if (take_req && !sel_we && sel_hit)
                dout_q[arb_idx*8 +: 8] <= lane_get(cdat_q[arb_idx], sel_addr[0]);
            if (acc_last) begin
                if (we_q) begin
                    // Any cache holding the written word, the writer's included, goes stale.
                    for (int i = 0; i < NCH; i++)
                        if (ctag_q[i] == waddr_q) cvld_q[i] <= 1'b0;
                    dout_q[gidx_q*8 +: 8] <= din_q;
                end else begin
                    cvld_q[gidx_q]        <= 1'b1;
                    dout_q[gidx_q*8 +: 8] <= lane_get(mem[waddr_q], lane_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take_req) begin
            gidx_q  <= arb_idx;
            waddr_q <= sel_addr[ADDR_W-1:1];
            lane_q  <= sel_addr[0];
            we_q    <= sel_we;
            din_q   <= sel_din;
        end
        if (acc_last && !we_q) begin
            ctag_q[gidx_q] <= waddr_q;
            cdat_q[gidx_q] <= mem[waddr_q];
        end
    end

    // Memory survives reset; a reset landing on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && acc_last && we_q)
            mem[waddr_q] <= lane_put(mem[waddr_q], lane_q, din_q);
    end

endmodule
